uart_word_link: RTL and testbench
=================================

# uart_word_link

Serial link stage directly downstream of the processor core's UART port. It consumes the core's 3-bit UART command and 32-bit transmit word, and serialises the word as four 8N1 frames on `tx`. It deserialises four frames from `rx` into the core's 32-bit receive word. It raises `wb_flag`, which the core's control unit uses as its ready/stall input, when each command completes.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: `clock` cycles per serial bit (50 MHz / 115200). Minimum legal value is 4.

Ports:
- `clock`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high.
- `uartc`  in  3  command from core: 3'b000 NOP, 3'b001 SEND, 3'b010 RECV. All other values are treated as NOP.
- `tx_data`  in  32  word to transmit (core `UART_out`).
- `rx_data`  out  32  last received word (core `UART_in`).
- `wb_flag`  out  1  command complete / ready.
- `busy`  out  1  high in states SEND and RECV.
- `ferr`  out  1  framing error seen on the last RECV.
- `perr`  out  1  parity error seen on the last RECV.
- `rx`  in  1  serial input; idles high; asynchronous.
- `tx`  out  1  serial output; idles high.

## Operation
- FSM states: IDLE, SEND, RECV, DONE.
- **IDLE**
  - `uartc` = SEND: latch `tx_data` into the shift word and go to SEND.
  - `uartc` = RECV: clear `ferr`/`perr`, zero the byte count, go to RECV.
  - Other values: stay in IDLE.
  - The accepted command value is stored as `cmd_q`.
- **SEND**
  - Transmits 4 frames back to back with no idle gap between them.
  - Byte order: `tx_data[7:0]` first, `[31:24]` last.
  - Frame: start bit 0, 8 data bits LSB first, stop bit 1.
  - After the last stop bit period, go to DONE.
- **RECV**
  - `rx` passes through a 2-flop synchroniser.
  - A falling edge of the synchronised `rx` starts a frame.
  - Re-sample `rx` at CLKS_PER_BIT/2. If it is high, the start was false: discard it and keep waiting.
  - Sample each data bit and the stop bit at the middle of its bit period.
  - A stop bit sampled 0 sets `ferr`. The byte is still kept.
  - Each byte is shifted into the assembly word at position byte_count×8.
  - After the 4th stop-bit sample, copy the assembly word to `rx_data` and go to DONE.
- **DONE**
  - `wb_flag` is 1.
  - Go to IDLE when `uartc` != `cmd_q`; `wb_flag` drops on that same transition.
  - Consequence: two identical consecutive commands need a NOP (or a different command) between them.
- `rx` activity outside RECV is ignored. There is no buffering; bytes arriving then are lost.
- `uartc` changes during SEND or RECV are ignored.
- `rx_data` holds its value until the next completed RECV.

## Timing
- Reset values:
  - state IDLE.
  - `tx` = 1, `wb_flag` = 0, `busy` = 0.
  - `rx_data` = 32'h0, `ferr` = 0, `perr` = 0.
- Reset mid-operation:
  - `tx` returns to 1 at the next edge.
  - The partially assembled word is discarded; `rx_data` is reset to 0.
- `tx` goes low on the first edge after SEND is accepted.
- Each bit is held for exactly CLKS_PER_BIT cycles.
- SEND latency: `wb_flag` rises 40×CLKS_PER_BIT+1 cycles after the accept edge (44× with parity enabled).
- RECV completion:
  - `rx_data`, `wb_flag` and the final `ferr`/`perr` update on the same edge.
  - That edge is the one on which the 4th stop bit is sampled.
- Input-to-sample delay: 2 cycles of synchroniser delay, included in the mid-bit sample point.
- Bit counter and baud counter:
  - both are free of wrap-around hazards;
  - the baud counter reloads at every bit boundary;
  - it is zeroed on entry to SEND and RECV.
- If a command is present on the cycle DONE exits, it is accepted on the following IDLE cycle.

## Configuration
- `UART_WORD_LINK_PARITY_EN` defined:
  - every frame carries an even-parity bit between data bit 7 and the stop bit;
  - TX computes the parity bit; RX checks it;
  - a mismatch sets `perr`, and the word is still delivered.
- Undefined:
  - frames are 8N1;
  - `perr` is tied to 0.

## Test plan
- **Reset:** assert `reset` for 2 cycles with `uartc` = NOP → `tx` = 1, `wb_flag` = 0, `busy` = 0, `rx_data` = 0.
- **SEND:** CLKS_PER_BIT = 4, `tx_data` = 32'hA1B2C3D4, `uartc` = SEND → `tx` carries bytes D4, C3, B2, A1 as 8N1 frames, 4 cycles per bit. `wb_flag` rises at cycle 161 and stays high until `uartc` = NOP, then falls.
- **RECV:** drive frames 0x78, 0x56, 0x34, 0x12 on `rx` with `uartc` = RECV → `rx_data` = 32'h12345678, `wb_flag` = 1, `ferr` = 0.
- **False start / framing error:**
  - a 1-cycle low glitch on `rx` in RECV → no byte is counted;
  - a frame with stop bit 0 → `ferr` = 1 at completion.
- **Parity** (with `UART_WORD_LINK_PARITY_EN`):
  - SEND 32'h00000001 → first frame has parity bit 1;
  - a received frame with wrong parity → `perr` = 1.
- **Reset mid-SEND:** assert `reset` after 2 frames → `tx` = 1 on the next edge, state IDLE, no `wb_flag`. A subsequent SEND transmits a full 4 frames.

Source files
------------

// File: rtl/uart_word_link.sv
// uart_word_link: moves 32-bit words over four UART frames (LSB byte first).
// Define UART_WORD_LINK_PARITY_EN to add an even-parity bit to every frame.
module uart_word_link #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  uartc,
  input  logic [31:0] tx_data,
  output logic [31:0] rx_data,
  output logic        wb_flag,
  output logic        busy,
  output logic        ferr,
  output logic        perr,
  input  logic        rx,
  output logic        tx
);

`ifdef UART_WORD_LINK_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int FRAME_BITS = PAR_EN ? 11 : 10;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [3:0] STOP_POS = 4'(FRAME_BITS - 1);
  localparam logic [3:0] PAR_POS  = 4'd9;
  localparam logic [2:0] CMD_SEND = 3'b001;
  localparam logic [2:0] CMD_RECV = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    RECV,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [2:0]    cmd_q;
  logic [31:0]   shift_q;
  logic [BW-1:0] baud_q;
  logic [3:0]    pos_q;
  logic [2:0]    byte_q;
  logic          tx_q, tx_d;
  logic          tx_par_q;
  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic          rx_act_q;
  logic [7:0]    rx_byte_q;
  logic [31:0]   asm_q, asm_d;
  logic [31:0]   rx_data_q;
  logic          ferr_q, perr_q;

  logic cmd_send, cmd_recv;
  logic baud_last, rx_fall, rx_last;

  assign cmd_send  = (uartc == CMD_SEND);
  assign cmd_recv  = (uartc == CMD_RECV);
  assign baud_last = (baud_q == BAUD_LAST);
  assign rx_fall   = rx_prev_q & ~rx_s2_q;

  // the 4th stop-bit sample completes a receive
  assign rx_last = rx_act_q && (pos_q == STOP_POS)
                && baud_last && (byte_q == 3'd3);

  // each finished byte enters at the top; after four, byte 0 sits at [7:0]
  assign asm_d = {rx_byte_q, asm_q[31:8]};

  assign tx      = tx_q;
  assign rx_data = rx_data_q;
  assign ferr    = ferr_q;
  assign perr    = PAR_EN ? perr_q : 1'b0;

  // state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_send)      state_d = SEND;
        else if (cmd_recv) state_d = RECV;
      end
      SEND: if (byte_q[2])        state_d = DONE;
      RECV: if (rx_last)          state_d = DONE;
      DONE: if (uartc != cmd_q)   state_d = IDLE;
    endcase
  end

  // outputs: status flags and the next serial tx level
  always_comb begin
    busy    = (state_q == SEND) || (state_q == RECV);
    wb_flag = (state_q == DONE);
    tx_d    = 1'b1;
    if (state_q == SEND && !byte_q[2]) begin
      unique case (1'b1)
        pos_q == 4'd0:                 tx_d = 1'b0;
        pos_q inside {[4'd1:4'd8]}:    tx_d = shift_q[0];
        PAR_EN && (pos_q == PAR_POS):  tx_d = tx_par_q;
        default:                       tx_d = 1'b1;
      endcase
    end
  end

  // datapath: synchroniser, baud/bit counters, shifters, status
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_q      <= 1'b1;
      cmd_q     <= '0;
      shift_q   <= '0;
      baud_q    <= '0;
      pos_q     <= '0;
      byte_q    <= '0;
      tx_par_q  <= 1'b0;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_act_q  <= 1'b0;
      rx_byte_q <= '0;
      asm_q     <= '0;
      rx_data_q <= '0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      tx_q      <= tx_d;
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      unique case (state_q)
        IDLE: begin
          baud_q   <= '0;
          pos_q    <= '0;
          byte_q   <= '0;
          rx_act_q <= 1'b0;
          if (cmd_send) begin
            shift_q <= tx_data;
            cmd_q   <= uartc;
          end
          if (cmd_recv) begin
            ferr_q <= 1'b0;
            perr_q <= 1'b0;
            cmd_q  <= uartc;
          end
        end
        SEND: begin
          if (!byte_q[2]) begin
            if (baud_last) begin
              baud_q <= '0;
              if (pos_q == 4'd0)
                tx_par_q <= ^shift_q[7:0];
              if (pos_q >= 4'd1 && pos_q <= 4'd8)
                shift_q <= {1'b0, shift_q[31:1]};
              if (pos_q == STOP_POS) begin
                pos_q  <= '0;
                byte_q <= byte_q + 3'd1;
              end else begin
                pos_q <= pos_q + 4'd1;
              end
            end else begin
              baud_q <= baud_q + BAUD_ONE;
            end
          end
        end
        RECV: begin
          if (!rx_act_q) begin
            if (rx_fall) begin
              rx_act_q <= 1'b1;
              baud_q   <= '0;
              pos_q    <= '0;
            end
          end else if (pos_q == 4'd0) begin
            // half-bit recheck rejects glitches posing as start bits
            if (baud_q == BAUD_HALF) begin
              baud_q <= '0;
              if (rx_s2_q) rx_act_q <= 1'b0;
              else         pos_q    <= 4'd1;
            end else begin
              baud_q <= baud_q + BAUD_ONE;
            end
          end else if (!baud_last) begin
            baud_q <= baud_q + BAUD_ONE;
          end else begin
            baud_q <= '0;
            pos_q  <= pos_q + 4'd1;
            if (pos_q <= 4'd8)
              rx_byte_q <= {rx_s2_q, rx_byte_q[7:1]};
            if (PAR_EN && pos_q == PAR_POS)
              perr_q <= perr_q | (^rx_byte_q ^ rx_s2_q);
            if (pos_q == STOP_POS) begin
              ferr_q   <= ferr_q | ~rx_s2_q;
              asm_q    <= asm_d;
              byte_q   <= byte_q + 3'd1;
              rx_act_q <= 1'b0;
              if (byte_q == 3'd3)
                rx_data_q <= asm_d;
            end
          end
        end
        DONE: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_link.sv
// tb_uart_word_link: randomized self-checking bench for uart_word_link.
// Frames are modelled from the byte/bit rules, independent of the RTL.
module tb_uart_word_link;

  localparam int CPB = 4;
`ifdef UART_WORD_LINK_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NBITS = PAR ? 11 : 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  uartc = 3'b000;
  logic [31:0] tx_data = '0;
  logic [31:0] rx_data;
  logic        wb_flag, busy, ferr, perr;
  logic        rx = 1'b1;
  logic        tx;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rx = '0;

  always #5 clk = ~clk;

  uart_word_link #(.CLKS_PER_BIT(CPB)) dut (
    .clock(clk), .reset(reset), .uartc(uartc),
    .tx_data(tx_data), .rx_data(rx_data),
    .wb_flag(wb_flag), .busy(busy),
    .ferr(ferr), .perr(perr), .rx(rx), .tx(tx)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, errors %0d", errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // serial level of position p in a frame carrying byte b
  function automatic logic frame_bit(input logic [7:0] b, input int p);
    if (p == 0) return 1'b0;
    if (p <= 8) return b[p-1];
    if (PAR && p == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic test_reset();
    reset = 1'b1; uartc = 3'b000; rx = 1'b1;
    tick(); tick();
    checks++;
    if (tx !== 1'b1 || wb_flag !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: tx=%b wb=%b busy=%b want 1 0 0", tx, wb_flag, busy);
    end
    checks++;
    if (rx_data !== 32'h0 || ferr !== 1'b0 || perr !== 1'b0) begin
      errors++;
      $display("FAIL reset_rx: rx_data=%h ferr=%b perr=%b want 0", rx_data, ferr, perr);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic do_send(input logic [31:0] w, input bit release_nop);
    int idx, k, p;
    logic e;
    uartc = 3'b001; tx_data = w;
    tick();
    tx_data = $urandom();
    for (int n = 1; n <= 4 * NBITS * CPB; n++) begin
      tick();
      idx = (n - 1) / CPB;
      k = idx / NBITS;
      p = idx % NBITS;
      e = frame_bit(w[8*k +: 8], p);
      checks++;
      if (tx !== e || wb_flag !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL send_bit word=%h cyc=%0d: tx=%b wb=%b busy=%b want %b 0 1",
                 w, n, tx, wb_flag, busy, e);
      end
    end
    tick();
    checks++;
    if (wb_flag !== 1'b1 || tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL send_done word=%h: wb=%b tx=%b busy=%b want 1 1 0",
               w, wb_flag, tx, busy);
    end
    repeat (3) tick();
    checks++;
    if (wb_flag !== 1'b1) begin
      errors++;
      $display("FAIL send_hold: wb=%b want 1", wb_flag);
    end
    if (release_nop) begin
      uartc = 3'b000;
      tick();
      checks++;
      if (wb_flag !== 1'b0) begin
        errors++;
        $display("FAIL send_release: wb=%b want 0", wb_flag);
      end
    end
  endtask

  task automatic drive_bit(input logic v, inout bit seen,
                           inout logic [31:0] gd, inout logic gf, inout logic gp);
    rx = v;
    repeat (CPB) begin
      tick();
      if (!seen && wb_flag === 1'b1) begin
        seen = 1'b1; gd = rx_data; gf = ferr; gp = perr;
      end
    end
  endtask

  task automatic do_recv(input logic [31:0] w, input logic [3:0] bad_stop,
                         input logic [3:0] bad_par, input bit glitch);
    bit seen = 1'b0;
    logic [31:0] gd = '0;
    logic gf = 1'b0, gp = 1'b0;
    logic [7:0] b;
    logic e, ef, ep;
    uartc = 3'b010;
    tick(); tick(); tick();
    checks++;
    if (busy !== 1'b1 || wb_flag !== 1'b0) begin
      errors++;
      $display("FAIL recv_start: busy=%b wb=%b want 1 0", busy, wb_flag);
    end
    if (glitch) begin
      rx = 1'b0; tick(); rx = 1'b1;
      repeat (3 * CPB) tick();
    end
    for (int f = 0; f < 4; f++) begin
      b = w[8*f +: 8];
      if (f == 3) begin
        checks++;
        if (rx_data !== exp_rx || wb_flag !== 1'b0) begin
          errors++;
          $display("FAIL recv_hold: rx_data=%h wb=%b want %h 0", rx_data, wb_flag, exp_rx);
        end
      end
      for (int p = 0; p < NBITS; p++) begin
        e = frame_bit(b, p);
        if (p == NBITS - 1 && bad_stop[f]) e = 1'b0;
        if (PAR && p == 9 && bad_par[f]) e = ~e;
        drive_bit(e, seen, gd, gf, gp);
      end
      rx = 1'b1;
      if (f < 3) repeat (2 * CPB) tick();
    end
    for (int i = 0; i < 4 * CPB && !seen; i++) begin
      tick();
      if (wb_flag === 1'b1) begin
        seen = 1'b1; gd = rx_data; gf = ferr; gp = perr;
      end
    end
    ef = |bad_stop;
    ep = PAR && (|bad_par);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL recv_timeout word=%h: wb=%b want 1", w, wb_flag);
    end else if (gd !== w || gf !== ef || gp !== ep) begin
      errors++;
      $display("FAIL recv_word: rx_data=%h ferr=%b perr=%b want %h %b %b",
               gd, gf, gp, w, ef, ep);
    end
    exp_rx = w;
    uartc = 3'b000;
    tick();
    checks++;
    if (wb_flag !== 1'b0 || busy !== 1'b0 || rx_data !== exp_rx) begin
      errors++;
      $display("FAIL recv_release: wb=%b busy=%b rx_data=%h want 0 0 %h",
               wb_flag, busy, rx_data, exp_rx);
    end
  endtask

  task automatic test_send();
    do_send(32'hA1B2C3D4, 1'b1);
    repeat (3) do_send($urandom(), 1'b1);
  endtask

  task automatic test_recv();
    do_recv(32'h12345678, 4'b0000, 4'b0000, 1'b0);
    repeat (3) do_recv($urandom(), 4'b0000, 4'b0000, 1'b0);
  endtask

  task automatic test_false_start();
    do_recv($urandom(), 4'b0000, 4'b0000, 1'b1);
  endtask

  task automatic test_framing_error();
    do_recv($urandom(), 4'b1000, 4'b0000, 1'b0);
    do_recv($urandom(), 4'($urandom_range(1, 15)), 4'b0000, 1'b0);
    do_recv($urandom(), 4'b0000, 4'b0000, 1'b0);
  endtask

  task automatic test_parity();
    do_send(32'h00000001, 1'b1);
    do_recv($urandom(), 4'b0000, 4'b0100, 1'b0);
    do_recv($urandom(), 4'b0000, 4'b0000, 1'b0);
  endtask

  task automatic test_rx_outside_recv();
    logic [7:0] b = 8'($urandom());
    for (int p = 0; p < NBITS; p++) begin
      rx = frame_bit(b, p);
      repeat (CPB) tick();
    end
    rx = 1'b1;
    checks++;
    if (busy !== 1'b0 || wb_flag !== 1'b0 || rx_data !== exp_rx) begin
      errors++;
      $display("FAIL rx_idle: busy=%b wb=%b rx_data=%h want 0 0 %h",
               busy, wb_flag, rx_data, exp_rx);
    end
    do_recv($urandom(), 4'b0000, 4'b0000, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_send($urandom(), 1'b0);
    do_recv($urandom(), 4'b0000, 4'b0000, 1'b0);
  endtask

  task automatic test_reset_mid_send();
    uartc = 3'b001; tx_data = $urandom();
    tick();
    repeat (2 * NBITS * CPB + 2) tick();
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midsend_pre: tx=%b busy=%b want 0 1", tx, busy);
    end
    reset = 1'b1; uartc = 3'b000;
    tick();
    exp_rx = '0;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || wb_flag !== 1'b0 || rx_data !== 32'h0) begin
      errors++;
      $display("FAIL midsend_reset: tx=%b busy=%b wb=%b rx_data=%h want 1 0 0 0",
               tx, busy, wb_flag, rx_data);
    end
    reset = 1'b0;
    repeat (3 * CPB) begin
      tick();
      checks++;
      if (tx !== 1'b1 || wb_flag !== 1'b0) begin
        errors++;
        $display("FAIL midsend_quiet: tx=%b wb=%b want 1 0", tx, wb_flag);
      end
    end
    do_send($urandom(), 1'b1);
  endtask

  initial begin
    test_reset();
    test_send();
    test_recv();
    test_false_start();
    test_framing_error();
    test_parity();
    test_rx_outside_recv();
    test_back_to_back();
    test_reset_mid_send();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
